req_gnt_checker: RTL and testbench

Parametrised multi-channel request/grant protocol checker for simulation benches and optional synthesis as an on-chip monitor. It samples `NCH` request/grant pairs every clock and tracks each channel with its own state machine. It flags protocol violations as registered one-cycle pulses and keeps saturating grant/error counters plus the worst-case observed grant latency. It sits passively beside any arbiter; it never drives `req` or `gnt`.

---
 rtl/req_gnt_checker.sv | 264 ++++++++++++++++++++++++++
 tb/tb_req_gnt_checker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_gnt_checker.sv
// req_gnt_checker
// ---------------------------------------------------------------------------
// Passive multi-channel request/grant protocol monitor. Each of the NCH
// channels is followed by its own small FSM (IDLE / WAIT / TMO / GRANT).
// Protocol violations are reported as registered one-cycle pulses. Saturating
// grant and error counters are kept, together with the worst request-to-grant
// latency observed. The block only observes req/gnt and never drives them.
//
// Parameters
//   NCH       number of request/grant channels (1..32)
//   MAX_WAIT  cycles a request may wait before a timeout is flagged (>=1)
//   CNT_W     width of the grant and error counters
//   LW        derived latency / wait-counter width, $clog2(MAX_WAIT+1)+1
//
// Ports
//   clk            sampling clock, rising edge
//   rst_n          asynchronous active-low reset
//   clr            synchronous clear of counters, latency max and FSMs
//   req[NCH]       per-channel request
//   gnt[NCH]       per-channel grant
//   v_gnt_no_req   pulse per channel: grant seen without a request
//   v_req_drop     pulse per channel: request withdrawn before grant
//   v_timeout      pulse per channel: wait reached MAX_WAIT
//   v_multi_gnt    pulse: more than one gnt bit high
//   gnt_cnt        accepted grants, saturating
//   err_cnt        violations, saturating
//   max_lat        largest request-to-grant latency seen
//
// Build option
//   REQ_GNT_CHK_ASSERT_EN  when defined, each violation also fires an
//   immediate assertion ($error with channel, type and time) and every
//   accepted grant is reported with its latency. Output behaviour is the
//   same with or without it; without it the block is synthesizable.
// ---------------------------------------------------------------------------
module req_gnt_checker #(
  parameter int NCH      = 4,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16,
  localparam int LW      = $clog2(MAX_WAIT + 1) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   gnt,
  output logic [NCH-1:0]   v_gnt_no_req,
  output logic [NCH-1:0]   v_req_drop,
  output logic [NCH-1:0]   v_timeout,
  output logic             v_multi_gnt,
  output logic [CNT_W-1:0] gnt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [LW-1:0]    max_lat
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_TMO,
    S_GRANT
  } ch_state_e;

  localparam logic [LW-1:0] MAX_W = LW'(MAX_WAIT);
  localparam logic [LW-1:0] ONE_W = LW'(1);

  // Sums are formed with headroom (up to 3*NCH+1 <= 97 bits can add in one
  // cycle) and then clamped, so the counters saturate instead of wrapping.
  localparam int SW = CNT_W + 8;
  localparam logic [SW-1:0] SAT = SW'({CNT_W{1'b1}});

  ch_state_e        state_q [NCH];
  ch_state_e        state_d [NCH];
  logic [LW-1:0]    wait_q  [NCH];
  logic [LW-1:0]    wait_d  [NCH];
  logic [LW-1:0]    lat_d   [NCH];
  logic [NCH-1:0]   acc_d;

  logic [NCH-1:0]   gnr_d,  gnr_q;
  logic [NCH-1:0]   drop_d, drop_q;
  logic [NCH-1:0]   tmo_d,  tmo_q;
  logic             multi_d, multi_q;
  logic [CNT_W-1:0] gnt_cnt_d, gnt_cnt_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic [LW-1:0]    max_lat_d, max_lat_q;
  logic [SW-1:0]    gnt_sum, err_sum;

  // -------------------------------------------------------------------------
  // Per-channel next state and violation detection
  // -------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      // NOTE: every variable gets a default before the case so no path
      // leaves it unassigned; that is what keeps this block latch-free.
      state_d[c] = state_q[c];
      wait_d[c]  = wait_q[c];
      lat_d[c]   = '0;
      acc_d[c]   = 1'b0;
      gnr_d[c]   = 1'b0;
      drop_d[c]  = 1'b0;
      tmo_d[c]   = 1'b0;

      unique case (state_q[c])
        S_IDLE: begin
          if (req[c] && gnt[c]) begin
            state_d[c] = S_GRANT;
            acc_d[c]   = 1'b1;
          end else if (req[c]) begin
            // A fresh request has already waited one edge; with MAX_WAIT=1
            // that is enough for an immediate timeout.
            wait_d[c] = ONE_W;
            if (MAX_W == ONE_W) begin
              state_d[c] = S_TMO;
              tmo_d[c]   = 1'b1;
            end else begin
              state_d[c] = S_WAIT;
            end
          end else if (gnt[c]) begin
            gnr_d[c] = 1'b1;
          end
        end

        S_WAIT, S_TMO: begin
          if (gnt[c]) begin
            // Grant accepted; a request dropped in the same cycle is a clean
            // completion, not a violation.
            acc_d[c]   = 1'b1;
            lat_d[c]   = wait_q[c];
            wait_d[c]  = '0;
            state_d[c] = req[c] ? S_GRANT : S_IDLE;
          end else if (!req[c]) begin
            drop_d[c]  = 1'b1;
            wait_d[c]  = '0;
            state_d[c] = S_IDLE;
          end else if (state_q[c] == S_WAIT) begin
            // TMO keeps wait_q frozen at MAX_WAIT and never re-fires.
            wait_d[c] = wait_q[c] + ONE_W;
            if (wait_q[c] + ONE_W == MAX_W) begin
              state_d[c] = S_TMO;
              tmo_d[c]   = 1'b1;
            end
          end
        end

        S_GRANT: begin
          if (!req[c]) begin
            state_d[c] = S_IDLE;
            gnr_d[c]   = gnt[c];
          end else if (!gnt[c]) begin
            // Request held past the grant: a new transaction starts.
            wait_d[c] = ONE_W;
            if (MAX_W == ONE_W) begin
              state_d[c] = S_TMO;
              tmo_d[c]   = 1'b1;
            end else begin
              state_d[c] = S_WAIT;
            end
          end
        end

        default: begin
          state_d[c] = S_IDLE;
          wait_d[c]  = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Global checks, counters and latency maximum
  // -------------------------------------------------------------------------
  always_comb begin
    multi_d = ($countones(gnt) > 1);

    gnt_sum   = SW'(gnt_cnt_q) + SW'($countones(acc_d));
    err_sum   = SW'(err_cnt_q) + SW'($countones({gnr_d, drop_d, tmo_d, multi_d}));
    gnt_cnt_d = (gnt_sum > SAT) ? {CNT_W{1'b1}} : gnt_sum[CNT_W-1:0];
    err_cnt_d = (err_sum > SAT) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];

    max_lat_d = max_lat_q;
    for (int c = 0; c < NCH; c++) begin
      if (acc_d[c] && (lat_d[c] > max_lat_d)) begin
        max_lat_d = lat_d[c];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers; clr acts as a synchronous reset and suppresses any violation
  // detected in the same cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-channel state and wait arrays are ordinary flops, not a
      // RAM, so they are reset like any other state register.
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= S_IDLE;
        wait_q[c]  <= '0;
      end
      gnr_q     <= '0;
      drop_q    <= '0;
      tmo_q     <= '0;
      multi_q   <= 1'b0;
      gnt_cnt_q <= '0;
      err_cnt_q <= '0;
      max_lat_q <= '0;
    end else if (clr) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= S_IDLE;
        wait_q[c]  <= '0;
      end
      gnr_q     <= '0;
      drop_q    <= '0;
      tmo_q     <= '0;
      multi_q   <= 1'b0;
      gnt_cnt_q <= '0;
      err_cnt_q <= '0;
      max_lat_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values; blocking ones would leak new state into this edge.
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        wait_q[c]  <= wait_d[c];
      end
      gnr_q     <= gnr_d;
      drop_q    <= drop_d;
      tmo_q     <= tmo_d;
      multi_q   <= multi_d;
      gnt_cnt_q <= gnt_cnt_d;
      err_cnt_q <= err_cnt_d;
      max_lat_q <= max_lat_d;
    end
  end

  assign v_gnt_no_req = gnr_q;
  assign v_req_drop   = drop_q;
  assign v_timeout    = tmo_q;
  assign v_multi_gnt  = multi_q;
  assign gnt_cnt      = gnt_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign max_lat      = max_lat_q;

`ifdef REQ_GNT_CHK_ASSERT_EN
  // Simulation-only reporting at the sampling edge that detects each event.
  always @(posedge clk) begin
    if (rst_n && !clr) begin
      for (int c = 0; c < NCH; c++) begin
        assert (!gnr_d[c])
          else $error("req_gnt_checker: ch%0d gnt_no_req at %0t", c, $time);
        assert (!drop_d[c])
          else $error("req_gnt_checker: ch%0d req_drop at %0t", c, $time);
        assert (!tmo_d[c])
          else $error("req_gnt_checker: ch%0d timeout at %0t", c, $time);
        if (acc_d[c]) begin
          $display("req_gnt_checker: ch%0d grant latency %0d at %0t",
                   c, lat_d[c], $time);
        end
      end
      assert (!multi_d)
        else $error("req_gnt_checker: multi_gnt 0x%0h at %0t", gnt, $time);
    end
  end
`endif

endmodule

// File: tb/tb_req_gnt_checker.sv
// Bench for req_gnt_checker: two instances share the stimulus, one with the
// default parameters (MAX_WAIT=8, CNT_W=16) and one at the boundary corner
// (MAX_WAIT=1, CNT_W=2). A transaction-level model predicts every output of
// both and is compared each cycle; directed literal checks pin the model.
module tb_req_gnt_checker;

  localparam int NCH = 4;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [3:0] req;
  logic [3:0] gnt;

  logic [3:0]  a_gnr, a_drop, a_tmo;
  logic        a_multi;
  logic [15:0] a_gcnt, a_ecnt;
  logic [4:0]  a_lat;

  logic [3:0]  b_gnr, b_drop, b_tmo;
  logic        b_multi;
  logic [1:0]  b_gcnt, b_ecnt;
  logic [1:0]  b_lat;

  int tests = 0;
  int fails = 0;

  req_gnt_checker #(.NCH(4), .MAX_WAIT(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .gnt(gnt),
    .v_gnt_no_req(a_gnr), .v_req_drop(a_drop), .v_timeout(a_tmo),
    .v_multi_gnt(a_multi), .gnt_cnt(a_gcnt), .err_cnt(a_ecnt), .max_lat(a_lat)
  );

  req_gnt_checker #(.NCH(4), .MAX_WAIT(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .gnt(gnt),
    .v_gnt_no_req(b_gnr), .v_req_drop(b_drop), .v_timeout(b_tmo),
    .v_multi_gnt(b_multi), .gnt_cnt(b_gcnt), .err_cnt(b_ecnt), .max_lat(b_lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: per channel, a request is either idle, waiting for `age` edges, or
  // inside a held grant. Index 0 mirrors dut_a's parameters, 1 dut_b's.
  // ---------------------------------------------------------------------------
  int         mw   [2] = '{8, 1};
  int         cmax [2] = '{65535, 3};
  int         age  [2][NCH];
  bit         held [2][NCH];
  logic [3:0] e_gnr [2], e_drop [2], e_tmo [2];
  bit         e_multi [2];
  int         e_gcnt [2], e_ecnt [2], e_lat [2];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCH; c++) begin
        age[k][c]  = 0;
        held[k][c] = 1'b0;
      end
      e_gnr[k] = '0; e_drop[k] = '0; e_tmo[k] = '0; e_multi[k] = 1'b0;
      e_gcnt[k] = 0; e_ecnt[k] = 0; e_lat[k] = 0;
    end
  endtask

  task automatic model_step();
    int ng;
    ng = 0;
    for (int c = 0; c < NCH; c++) if (gnt[c]) ng++;
    for (int k = 0; k < 2; k++) begin
      int acc, viol;
      acc = 0; viol = 0;
      for (int c = 0; c < NCH; c++) begin
        bit r, g;
        r = req[c]; g = gnt[c];
        e_gnr[k][c] = 1'b0; e_drop[k][c] = 1'b0; e_tmo[k][c] = 1'b0;
        if (held[k][c]) begin
          held[k][c] = r && g;
          if (!r && g) e_gnr[k][c] = 1'b1;
          else if (r && !g) begin
            age[k][c] = 1;
            if (mw[k] == 1) e_tmo[k][c] = 1'b1;
          end
        end else if (age[k][c] > 0) begin
          if (g) begin
            acc++;
            if (age[k][c] > e_lat[k]) e_lat[k] = age[k][c];
            held[k][c] = r;
            age[k][c]  = 0;
          end else if (!r) begin
            e_drop[k][c] = 1'b1;
            age[k][c]    = 0;
          end else if (age[k][c] < mw[k]) begin
            age[k][c]++;
            if (age[k][c] == mw[k]) e_tmo[k][c] = 1'b1;
          end
        end else begin
          if (r && g) begin
            acc++;
            held[k][c] = 1'b1;
          end else if (r) begin
            age[k][c] = 1;
            if (mw[k] == 1) e_tmo[k][c] = 1'b1;
          end else if (g) begin
            e_gnr[k][c] = 1'b1;
          end
        end
        viol += int'(e_gnr[k][c]) + int'(e_drop[k][c]) + int'(e_tmo[k][c]);
      end
      e_multi[k] = (ng > 1);
      viol += int'(e_multi[k]);
      e_gcnt[k] = (e_gcnt[k] + acc > cmax[k]) ? cmax[k] : e_gcnt[k] + acc;
      e_ecnt[k] = (e_ecnt[k] + viol > cmax[k]) ? cmax[k] : e_ecnt[k] + viol;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) model_clear();
    else model_step();
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    check("A.v_gnt_no_req", a_gnr,   e_gnr[0]);
    check("A.v_req_drop",   a_drop,  e_drop[0]);
    check("A.v_timeout",    a_tmo,   e_tmo[0]);
    check("A.v_multi_gnt",  a_multi, e_multi[0]);
    check("A.gnt_cnt",      a_gcnt,  e_gcnt[0]);
    check("A.err_cnt",      a_ecnt,  e_ecnt[0]);
    check("A.max_lat",      a_lat,   e_lat[0]);
    check("B.v_gnt_no_req", b_gnr,   e_gnr[1]);
    check("B.v_req_drop",   b_drop,  e_drop[1]);
    check("B.v_timeout",    b_tmo,   e_tmo[1]);
    check("B.v_multi_gnt",  b_multi, e_multi[1]);
    check("B.gnt_cnt",      b_gcnt,  e_gcnt[1]);
    check("B.err_cnt",      b_ecnt,  e_ecnt[1]);
    check("B.max_lat",      b_lat,   e_lat[1]);
  end

  // One call = inputs sampled at the next rising edge, results visible after.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int tmo_pulses;
    rst_n = 1'b0; clr = 1'b0; req = '0; gnt = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    check("reset A.gnt_cnt", a_gcnt, 0);
    check("reset A.max_lat", a_lat, 0);

    // Ch0: request waits 3 edges, grant held 2 cycles.
    tick(); tick();
    req = 4'b0001;
    repeat (3) tick();
    gnt = 4'b0001;
    tick(); tick();
    req = '0; gnt = '0;
    tick();
    check("ch0 A.gnt_cnt", a_gcnt, 1);
    check("ch0 A.max_lat", a_lat, 3);
    check("ch0 A.err_cnt", a_ecnt, 0);
    check("ch0 B.max_lat", b_lat, 1);
    check("ch0 B.err_cnt", b_ecnt, 1);

    // Ch1: grant without request.
    do_clr();
    gnt = 4'b0010;
    tick();
    check("ch1 A.v_gnt_no_req", a_gnr, 4'b0010);
    gnt = '0;
    tick();
    check("ch1 A.pulse_end", a_gnr, 4'b0000);
    check("ch1 A.err_cnt", a_ecnt, 1);

    // Ch2: timeout after 8 waiting edges, then a drop.
    do_clr();
    req = 4'b0100;
    tmo_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_tmo[2]) tmo_pulses++;
      if (i == 0) check("ch2 B.timeout_mw1", b_tmo, 4'b0100);
    end
    check("ch2 A.timeout_pulses", tmo_pulses, 1);
    req = '0;
    tick();
    check("ch2 A.v_req_drop", a_drop, 4'b0100);
    tick();
    check("ch2 A.err_cnt", a_ecnt, 2);
    check("ch2 B.err_cnt", b_ecnt, 2);

    // Two grants at once.
    do_clr();
    req = 4'b0011; gnt = 4'b0011;
    tick();
    check("multi A.v_multi_gnt", a_multi, 1);
    check("multi A.gnt_cnt", a_gcnt, 2);
    check("multi A.err_cnt", a_ecnt, 1);
    req = '0; gnt = '0;
    tick();

    // Saturation, then clr coinciding with a violation.
    do_clr();
    for (int i = 0; i < 5; i++) begin
      req = 4'b0001; gnt = 4'b0001; tick();
      req = '0;      gnt = '0;      tick();
    end
    check("sat B.gnt_cnt", b_gcnt, 3);
    check("sat A.gnt_cnt", a_gcnt, 5);
    clr = 1'b1; gnt = 4'b0010;
    tick();
    clr = 1'b0; gnt = '0;
    check("clr A.gnt_cnt", a_gcnt, 0);
    check("clr B.gnt_cnt", b_gcnt, 0);
    check("clr A.v_gnt_no_req", a_gnr, 0);
    tick();
    check("clr A.err_cnt", a_ecnt, 0);

    // Asynchronous reset in the middle of a ch3 wait.
    req = 4'b0001; gnt = 4'b0001;
    tick();
    req = 4'b1000; gnt = '0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("async A.gnt_cnt", a_gcnt, 0);
    check("async B.err_cnt", b_ecnt, 0);
    check("async B.v_timeout", b_tmo, 0);
    req = '0;
    tick();
    rst_n = 1'b1;
    gnt = 4'b1000;
    tick();
    check("post-rst A.v_gnt_no_req", a_gnr, 4'b1000);
    check("post-rst A.err_cnt", a_ecnt, 1);
    check("post-rst A.v_req_drop", a_drop, 0);
    gnt = '0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
